// File: rtl/synth_pkg.sv
// Shared scan-code constants, parser state encoding and the note-key decoder
// used by the polyphonic voice allocator.
package synth_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 3;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_C     = 8'h1C;
  localparam logic [7:0] SC_CS    = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h1B;
  localparam logic [7:0] SC_DS    = 8'h24;
  localparam logic [7:0] SC_E     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_FS    = 8'h2C;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_GS    = 8'h35;
  localparam logic [7:0] SC_A     = 8'h33;
  localparam logic [7:0] SC_AS    = 8'h3C;
  localparam logic [7:0] SC_B     = 8'h3B;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_BRK     = 2'd1,
    PS_EXT     = 2'd2,
    PS_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic              valid;
    logic [NOTE_W-1:0] note;
  } note_code_t;

  // Maps a scan code to a semitone 0=C..11=B; valid is low for non-note keys.
  function automatic note_code_t keycode_to_note(input logic [7:0] code);
    note_code_t r;
    r.valid = 1'b1;
    r.note  = '0;
    case (code)
      SC_C:    r.note = 4'd0;
      SC_CS:   r.note = 4'd1;
      SC_D:    r.note = 4'd2;
      SC_DS:   r.note = 4'd3;
      SC_E:    r.note = 4'd4;
      SC_F:    r.note = 4'd5;
      SC_FS:   r.note = 4'd6;
      SC_G:    r.note = 4'd7;
      SC_GS:   r.note = 4'd8;
      SC_A:    r.note = 4'd9;
      SC_AS:   r.note = 4'd10;
      SC_B:    r.note = 4'd11;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_make_break_parser.sv
// Turns the PS/2 byte stream into make/break events for the 12 note keys.
// Events are combinational in the strobe cycle so the allocator acts at the next edge.
module ps2_make_break_parser
  import synth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_pressed,
  input  logic [7:0]        key_data,
  output logic              make_evt,
  output logic              brk_evt,
  output logic [NOTE_W-1:0] note
);

  parse_state_e state_q, state_d;
  note_code_t   code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PS_IDLE;
    else        state_q <= state_d;
  end

  // Extended-prefix sequences are swallowed whole so E0-prefixed keys never alias notes.
  always_comb begin
    state_d = state_q;
    if (key_pressed) begin
      case (state_q)
        PS_IDLE: begin
          if (key_data == SC_BREAK)    state_d = PS_BRK;
          else if (key_data == SC_EXT) state_d = PS_EXT;
          else                         state_d = PS_IDLE;
        end
        PS_EXT:  state_d = (key_data == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
        default: state_d = PS_IDLE;
      endcase
    end
  end

  always_comb begin
    code     = keycode_to_note(key_data);
    make_evt = key_pressed && (state_q == PS_IDLE) && code.valid;
    brk_evt  = key_pressed && (state_q == PS_BRK)  && code.valid;
    note     = code.note;
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice controller: assigns note keys to voices with LRU ranking.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice when all are gated.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        ps2_key_pressed,
  input  logic [7:0]                  ps2_key_data,
  input  logic [2:0]                  octave,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [4*NUM_VOICES-1:0]     voice_note,
  output logic [3*NUM_VOICES-1:0]     voice_octave,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        steal
);

  logic              make_evt, brk_evt;
  logic [NOTE_W-1:0] evt_note;

  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic                  steal_q;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [OCT_W-1:0]      oct_q  [NUM_VOICES];
  logic [AGE_W-1:0]      rank_q [NUM_VOICES];

  logic             hit, free_found, alloc_c, steal_c;
  logic [AGE_W-1:0] free_idx, lru_idx, target, tgt_rank;

  ps2_make_break_parser u_parser (
    .clk         (CLOCK_50),
    .rst_n       (resetn),
    .key_pressed (ps2_key_pressed),
    .key_data    (ps2_key_data),
    .make_evt    (make_evt),
    .brk_evt     (brk_evt),
    .note        (evt_note)
  );

  // Victim selection: repeat detection, lowest free voice and LRU voice.
  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    lru_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = AGE_W'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_q[i] && (note_q[i] == evt_note) && (oct_q[i] == octave)) hit = 1'b1;
      if (rank_q[i] == AGE_W'(NUM_VOICES - 1)) lru_idx = AGE_W'(i);
    end
    target   = free_found ? free_idx : lru_idx;
    tgt_rank = rank_q[target];
`ifdef VOICE_ALLOC_STEAL_EN
    alloc_c = make_evt && !hit;
    steal_c = alloc_c && !free_found;
`else
    alloc_c = make_evt && !hit && free_found;
    steal_c = 1'b0;
`endif
  end

  // Note and octave are kept on release so the voice's release tail keeps its pitch.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      gate_q  <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        oct_q[i]  <= '0;
        rank_q[i] <= AGE_W'(i);
      end
    end else begin
      trig_q  <= '0;
      steal_q <= steal_c;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (alloc_c && (target == AGE_W'(i))) begin
          gate_q[i] <= 1'b1;
          trig_q[i] <= 1'b1;
          note_q[i] <= evt_note;
          oct_q[i]  <= octave;
          rank_q[i] <= '0;
        end else begin
          if (alloc_c && (rank_q[i] < tgt_rank)) rank_q[i] <= rank_q[i] + AGE_W'(1);
          if (brk_evt && gate_q[i] && (note_q[i] == evt_note)) gate_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
    assign voice_note[4*g +: 4]   = note_q[g];
    assign voice_octave[3*g +: 3] = oct_q[g];
  end

  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign steal      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed, table-driven bench for voice_allocator (4 voices); expectations
// follow VOICE_ALLOC_STEAL_EN when the bench is built with it.
module tb_voice_allocator;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic [2:0]  octave;
  logic [3:0]  voice_gate;
  logic [15:0] voice_note;
  logic [11:0] voice_octave;
  logic [3:0]  voice_trig;
  logic        steal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  oct;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic        stl;
    logic [15:0] notes;
    logic [11:0] octs;
  } vec_t;

  vec_t vecs[$];

  voice_allocator dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .octave          (octave),
    .voice_gate      (voice_gate),
    .voice_note      (voice_note),
    .voice_octave    (voice_octave),
    .voice_trig      (voice_trig),
    .steal           (steal)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [11:0] o4(input int v3, input int v2, input int v1, input int v0);
    return {3'(v3), 3'(v2), 3'(v1), 3'(v0)};
  endfunction

  task automatic add(input logic [7:0] d, input logic [2:0] o, input logic [3:0] g,
                     input logic [3:0] t, input logic s, input logic [15:0] n,
                     input logic [11:0] oc);
    vec_t v;
    v.data = d; v.oct = o; v.gate = g; v.trig = t; v.stl = s; v.notes = n; v.octs = oc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] t,
                         input logic s, input logic [15:0] n, input logic [11:0] oc);
    chk({tag, " gate"},   32'(voice_gate),   32'(g));
    chk({tag, " trig"},   32'(voice_trig),   32'(t));
    chk({tag, " steal"},  32'(steal),        32'(s));
    chk({tag, " note"},   32'(voice_note),   32'(n));
    chk({tag, " octave"}, 32'(voice_octave), 32'(oc));
  endtask

  // One strobe per cycle; outputs are examined 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] b, input logic [2:0] o);
    @(negedge CLOCK_50);
    ps2_key_data    = b;
    octave          = o;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50);
    #1;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #3 resetn = 1'b0;
    #1 chk_all(tag, 4'h0, 4'h0, 1'b0, 16'h0000, 12'h000);
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  initial begin
    resetn          = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    octave          = 3'd0;

    add(8'h1C, 3'd4, 4'h1, 4'h1, 1'b0, 16'h0000, o4(0,0,0,4));
    add(8'h1B, 3'd4, 4'h3, 4'h2, 1'b0, 16'h0020, o4(0,0,4,4));
    add(8'h1C, 3'd4, 4'h3, 4'h0, 1'b0, 16'h0020, o4(0,0,4,4));
    add(8'h1C, 3'd4, 4'h3, 4'h0, 1'b0, 16'h0020, o4(0,0,4,4));
    add(8'hF0, 3'd4, 4'h3, 4'h0, 1'b0, 16'h0020, o4(0,0,4,4));
    add(8'h1C, 3'd4, 4'h2, 4'h0, 1'b0, 16'h0020, o4(0,0,4,4));
    add(8'h1C, 3'd5, 4'h3, 4'h1, 1'b0, 16'h0020, o4(0,0,4,5));
    add(8'h1C, 3'd4, 4'h7, 4'h4, 1'b0, 16'h0020, o4(0,4,4,5));
    add(8'h23, 3'd4, 4'hF, 4'h8, 1'b0, 16'h4020, o4(4,4,4,5));
`ifdef VOICE_ALLOC_STEAL_EN
    add(8'h34, 3'd6, 4'hF, 4'h2, 1'b1, 16'h4070, o4(4,4,6,5));
    add(8'hF0, 3'd6, 4'hF, 4'h0, 1'b0, 16'h4070, o4(4,4,6,5));
    add(8'h1C, 3'd6, 4'hA, 4'h0, 1'b0, 16'h4070, o4(4,4,6,5));
    add(8'h2B, 3'd3, 4'hB, 4'h1, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'hE0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'h1C, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'hE0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'hF0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'h1C, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4075, o4(4,4,6,3));
    add(8'h1C, 3'd2, 4'hF, 4'h4, 1'b0, 16'h4075, o4(4,2,6,3));
    add(8'h00, 3'd2, 4'hF, 4'h0, 1'b0, 16'h4075, o4(4,2,6,3));
    add(8'h3B, 3'd1, 4'hF, 4'h8, 1'b1, 16'hB075, o4(1,2,6,3));
`else
    add(8'h34, 3'd6, 4'hF, 4'h0, 1'b0, 16'h4020, o4(4,4,4,5));
    add(8'hF0, 3'd6, 4'hF, 4'h0, 1'b0, 16'h4020, o4(4,4,4,5));
    add(8'h1C, 3'd6, 4'hA, 4'h0, 1'b0, 16'h4020, o4(4,4,4,5));
    add(8'h2B, 3'd3, 4'hB, 4'h1, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'hE0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'h1C, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'hE0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'hF0, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'h1C, 3'd3, 4'hB, 4'h0, 1'b0, 16'h4025, o4(4,4,4,3));
    add(8'h1C, 3'd2, 4'hF, 4'h4, 1'b0, 16'h4025, o4(4,2,4,3));
    add(8'h00, 3'd2, 4'hF, 4'h0, 1'b0, 16'h4025, o4(4,2,4,3));
    add(8'h3B, 3'd1, 4'hF, 4'h0, 1'b0, 16'h4025, o4(4,2,4,3));
`endif

    do_reset("reset0");
    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].oct);
      chk_all($sformatf("v%0d", k), vecs[k].gate, vecs[k].trig, vecs[k].stl,
              vecs[k].notes, vecs[k].octs);
    end

    // Five distinct makes: the fifth finds every voice gated.
    do_reset("reset1");
    send(8'h1C, 3'd4);
    send(8'h1B, 3'd4);
    send(8'h23, 3'd4);
    send(8'h2B, 3'd4);
    chk_all("four", 4'hF, 4'h8, 1'b0, 16'h5420, o4(4,4,4,4));
    send(8'h34, 3'd4);
`ifdef VOICE_ALLOC_STEAL_EN
    chk_all("fifth", 4'hF, 4'h1, 1'b1, 16'h5427, o4(4,4,4,4));
`else
    chk_all("fifth", 4'hF, 4'h0, 1'b0, 16'h5420, o4(4,4,4,4));
`endif
    send(8'h00, 3'd4);
    chk({"after fifth", " steal"}, 32'(steal), 32'd0);
    chk({"after fifth", " trig"},  32'(voice_trig), 32'd0);

    // Reset while the parser waits for a break code must return it to IDLE.
    send(8'hF0, 3'd4);
    do_reset("reset2");
    send(8'h1C, 3'd4);
    chk_all("post_reset_make", 4'h1, 4'h1, 1'b0, 16'h0000, o4(0,0,0,4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
